// File: rtl/stopwatch_pkg.sv
// Stopwatch controller shared definitions.
// Holds the FSM state encoding and the seconds datapath width used by the
// controller, its lap-FIFO interface and the testbench.
package stopwatch_pkg;

  // Width of the seconds count captured into the lap FIFO.
  localparam int SEC_W = 8;

  // FSM encoding; the numeric values are visible on the state output.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_CLEAR = 2'd3
  } state_e;

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Lap FIFO read bus of the stopwatch controller.
// Signals:
//   lap_rd    - pop request for the FIFO head (consumer -> controller)
//   lap_data  - FIFO head, show-ahead, 0 when empty
//   lap_valid - FIFO not empty
//   lap_ovf   - sticky: a lap capture was dropped because the FIFO was full
// Modports: master = consumer side, slave = controller side.
interface stopwatch_ctrl_if;
  import stopwatch_pkg::*;

  logic             lap_rd;
  logic [SEC_W-1:0] lap_data;
  logic             lap_valid;
  logic             lap_ovf;

  modport master (output lap_rd, input lap_data, input lap_valid, input lap_ovf);
  modport slave  (input lap_rd, output lap_data, output lap_valid, output lap_ovf);

endinterface

// File: rtl/btn_debounce.sv
// Button conditioning: 2-flop synchronizer, debounce counter and a one-cycle
// press pulse on the debounced rising edge.
// Ports:
//   clk, rst - clock, asynchronous active-high reset
//   i_raw    - raw button level, asynchronous to clk
//   o_pulse  - registered one-cycle pulse when the debounced level rises
module btn_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_pulse
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_level_d;
  logic          r_pulse;
  logic [CW-1:0] r_cnt;

  // Two-flop synchronizer for the asynchronous raw input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Counts consecutive samples that disagree with the debounced level; the
  // level flips on the DEB_CYCLES-th such sample, any agreeing sample restarts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_level <= 1'b0;
      r_cnt   <= {CW{1'b0}};
    end else if (r_sync2 == r_level) begin
      r_level <= r_level;
      r_cnt   <= {CW{1'b0}};
    end else if (r_cnt == CNT_LAST) begin
      r_level <= r_sync2;
      r_cnt   <= {CW{1'b0}};
    end else begin
      r_level <= r_level;
      r_cnt   <= r_cnt + CW'(1);
    end
  end

  // Registered rising-edge detect of the debounced level (no release event).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_level_d <= 1'b0;
      r_pulse   <= 1'b0;
    end else begin
      r_level_d <= r_level;
      r_pulse   <= r_level & ~r_level_d;
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: debounced start/reset/lap buttons drive an
// IDLE/RUN/PAUSE/CLEAR FSM; lap presses in RUN capture the seconds count
// into a small show-ahead FIFO.
// Ports:
//   clk, rst           - clock, asynchronous active-high reset
//   i_btn_*_raw        - raw buttons (start/stop, reset, lap)
//   i_seconds_in       - current seconds count from the counter datapath
//   o_cnt_en           - counter increment enable (RUN)
//   o_cnt_clr          - one-cycle counter clear (CLEAR)
//   o_state            - current FSM state encoding
//   lap_if             - lap FIFO read bus (slave side)
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DEB_CYCLES = 4,
  parameter int LAP_DEPTH  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_btn_start_raw,
  input  logic             i_btn_reset_raw,
  input  logic             i_btn_lap_raw,
  input  logic [SEC_W-1:0] i_seconds_in,
  output logic             o_cnt_en,
  output logic             o_cnt_clr,
  output logic [1:0]       o_state,
  stopwatch_ctrl_if.slave  lap_if
);

  localparam int AW = $clog2(LAP_DEPTH);

  logic w_start_ev;
  logic w_reset_ev;
  logic w_lap_ev;

  state_e r_state;
  state_e w_next_state;

  logic [SEC_W-1:0] r_mem [LAP_DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             r_ovf;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_push_req;
  logic             w_push;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start (
    .clk(clk), .rst(rst), .i_raw(i_btn_start_raw), .o_pulse(w_start_ev)
  );
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_reset (
    .clk(clk), .rst(rst), .i_raw(i_btn_reset_raw), .o_pulse(w_reset_ev)
  );
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_lap (
    .clk(clk), .rst(rst), .i_raw(i_btn_lap_raw), .o_pulse(w_lap_ev)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next state; the reset event is tested first so it wins over start.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_reset_ev) w_next_state = ST_CLEAR;
        else if (w_start_ev) w_next_state = ST_RUN;
        else w_next_state = ST_IDLE;
      end
      ST_RUN: begin
        if (w_reset_ev) w_next_state = ST_CLEAR;
        else if (w_start_ev) w_next_state = ST_PAUSE;
        else w_next_state = ST_RUN;
      end
      ST_PAUSE: begin
        if (w_reset_ev) w_next_state = ST_CLEAR;
        else if (w_start_ev) w_next_state = ST_RUN;
        else w_next_state = ST_PAUSE;
      end
      ST_CLEAR: w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  assign o_state   = r_state;
  assign o_cnt_en  = (r_state == ST_RUN);
  assign o_cnt_clr = (r_state == ST_CLEAR);

  // Extra wrap bit distinguishes full from empty when the indices match.
  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop      = lap_if.lap_rd && !w_empty;
  assign w_push_req = w_lap_ev && (r_state == ST_RUN);
  // A pop in the same cycle frees the head slot, so a push when full proceeds.
  assign w_push     = w_push_req && (!w_full || w_pop);

  // FIFO pointers and sticky overflow; CLEAR flushes both.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= {(AW+1){1'b0}};
      r_rd_ptr <= {(AW+1){1'b0}};
      r_ovf    <= 1'b0;
    end else if (r_state == ST_CLEAR) begin
      r_wr_ptr <= {(AW+1){1'b0}};
      r_rd_ptr <= {(AW+1){1'b0}};
      r_ovf    <= 1'b0;
    end else begin
      r_wr_ptr <= w_push ? (r_wr_ptr + (AW+1)'(1)) : r_wr_ptr;
      r_rd_ptr <= w_pop  ? (r_rd_ptr + (AW+1)'(1)) : r_rd_ptr;
      r_ovf    <= r_ovf | (w_push_req && !w_push);
    end
  end

  // FIFO storage; contents are only observed through non-empty slots.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_seconds_in;
    end
  end

  assign lap_if.lap_data  = w_empty ? {SEC_W{1'b0}} : r_mem[r_rd_ptr[AW-1:0]];
  assign lap_if.lap_valid = !w_empty;
  assign lap_if.lap_ovf   = r_ovf;

endmodule
